// File: rtl/common_types_pkg.sv
// Shared types for the instruction/data memory arbiter.
package common_types_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

  localparam logic [3:0] STRB_ALL      = 4'b1111;
  localparam int         STARVE_CW_MIN = 3;

  // Counter must hold STARVE_MAX itself, never narrower than 3 bits.
  function automatic int starve_cw(input int max_cnt);
    int w;
    w = $clog2(max_cnt + 1);
    return (w < STARVE_CW_MIN) ? STARVE_CW_MIN : w;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side fetch/load/store ports and the single-port RAM bus of the arbiter.
interface mem_arbiter_if;

  logic        iread;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;

  logic        dread;
  logic        dwrite;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [3:0]  dstrobe;
  logic        dhit;
  logic [31:0] dload;

  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_strobe;
  logic [31:0] ram_rdata;
  logic        ram_ready;

  // Arbiter side.
  modport slave (
    input  iread, iaddr, dread, dwrite, daddr, dstore, dstrobe, ram_rdata, ram_ready,
    output ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_wdata, ram_strobe
  );

  // Environment side: the CPU requesters plus the RAM.
  modport master (
    output iread, iaddr, dread, dwrite, daddr, dstore, dstrobe, ram_rdata, ram_ready,
    input  ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_wdata, ram_strobe
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data accesses onto one RAM port; data wins
// unless a waiting fetch has already been passed over STARVE_MAX times in a row.
module mem_arbiter
  import common_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          nrst,
  mem_arbiter_if.slave  bus
);

  localparam int            CW         = starve_cw(STARVE_MAX);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_cnt_nxt;

  logic          d_req;
  logic          i_starved;
  logic          ihit_c;
  logic          dhit_c;
  logic          ram_ren_c;
  logic          ram_wen_c;
  logic [31:0]   ram_addr_c;
  logic [31:0]   ram_wdata_c;
  logic [3:0]    ram_strobe_c;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    ihit_c         = 1'b0;
    dhit_c         = 1'b0;
    ram_ren_c      = 1'b0;
    ram_wen_c      = 1'b0;
    ram_addr_c     = '0;
    ram_wdata_c    = '0;
    ram_strobe_c   = '0;

    d_req     = bus.dread | bus.dwrite;
    i_starved = bus.iread && (starve_cnt == STARVE_LIM);

    unique case (state)
      IDLE: begin
        if (d_req && !i_starved) begin
          state_nxt = DBUSY;
          if (bus.iread) begin
            starve_cnt_nxt = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + CW'(1);
          end else begin
            starve_cnt_nxt = '0;
          end
        end else if (bus.iread) begin
          state_nxt      = IBUSY;
          starve_cnt_nxt = '0;
        end else begin
          starve_cnt_nxt = '0;
        end
      end

      IBUSY: begin
        ram_ren_c    = 1'b1;
        ram_addr_c   = bus.iaddr;
        ram_strobe_c = STRB_ALL;
        ihit_c       = bus.ram_ready;
        // A fetch withdrawn before completion (pipeline flush) is dropped silently.
        if (bus.ram_ready || !bus.iread) begin
          state_nxt = IDLE;
        end
      end

      DBUSY: begin
        // A simultaneous read and write request is serviced as a write only.
        ram_ren_c    = bus.dread & ~bus.dwrite;
        ram_wen_c    = bus.dwrite;
        ram_addr_c   = bus.daddr;
        ram_wdata_c  = bus.dstore;
        ram_strobe_c = bus.dwrite ? bus.dstrobe : STRB_ALL;
        dhit_c       = bus.ram_ready;
        if (bus.ram_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt      = IDLE;
        starve_cnt_nxt = '0;
      end
    endcase
  end

  assign bus.ihit       = ihit_c;
  assign bus.dhit       = dhit_c;
  assign bus.ram_ren    = ram_ren_c;
  assign bus.ram_wen    = ram_wen_c;
  assign bus.ram_addr   = ram_addr_c;
  assign bus.ram_wdata  = ram_wdata_c;
  assign bus.ram_strobe = ram_strobe_c;
  assign bus.iload      = nrst ? bus.ram_rdata : '0;
  assign bus.dload      = nrst ? bus.ram_rdata : '0;

  hits_exclusive: assert property (@(posedge clk) disable iff (!nrst)
    !(bus.ihit && bus.dhit));

  dbusy_held: assert property (@(posedge clk) disable iff (!nrst)
    (state == DBUSY && !bus.ram_ready) |=> (state == DBUSY));

  starve_bounded: assert property (@(posedge clk) disable iff (!nrst)
    starve_cnt <= STARVE_LIM);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, contention, starvation, abort, mid-access reset.
module tb_mem_arbiter;
  import common_types_pkg::*;

  logic clk;
  logic nrst;
  int   n_vec;
  int   n_err;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.iread     = 1'b0;
    bus.iaddr     = '0;
    bus.dread     = 1'b0;
    bus.dwrite    = 1'b0;
    bus.daddr     = '0;
    bus.dstore    = '0;
    bus.dstrobe   = '0;
    bus.ram_rdata = '0;
    bus.ram_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    nrst  = 1'b0;
    clear_inputs();
    bus.ram_rdata = 32'hFFFF_FFFF;

    // Reset: outputs quiet, read data gated.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_iload", bus.iload, 32'h0);
    chk("rst_dload", bus.dload, 32'h0);
    chk("rst_ren", 32'(bus.ram_ren), 0);
    chk("rst_wen", 32'(bus.ram_wen), 0);
    chk("rst_hits", 32'({bus.ihit, bus.dhit}), 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    nrst = 1'b1;
    bus.ram_rdata = '0;
    @(negedge clk); #1;
    chk("post_rst_state", 32'(dut.state), 32'(IDLE));
    chk("post_rst_cnt", 32'(dut.starve_cnt), 0);
    chk("post_rst_bus", 32'({bus.ram_ren, bus.ram_wen, bus.ram_strobe}), 0);
    chk("post_rst_addr", bus.ram_addr, 32'h0);

    // Single fetch, RAM answers on the third IBUSY cycle.
    @(negedge clk);
    bus.iread = 1'b1;
    bus.iaddr = 32'h100;
    #1;
    chk("f_idle_ren", 32'(bus.ram_ren), 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("f_wait_ren", 32'(bus.ram_ren), 1);
      chk("f_wait_addr", bus.ram_addr, 32'h100);
      chk("f_wait_ihit", 32'(bus.ihit), 0);
    end
    @(negedge clk);
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 32'h0050_0093;
    #1;
    chk("f_ihit", 32'(bus.ihit), 1);
    chk("f_iload", bus.iload, 32'h0050_0093);
    chk("f_addr", bus.ram_addr, 32'h100);
    chk("f_strobe", 32'(bus.ram_strobe), 32'hF);
    @(negedge clk);
    bus.iread = 1'b0;
    bus.ram_ready = 1'b0;
    bus.ram_rdata = '0;
    #1;
    chk("f_ihit_clr", 32'(bus.ihit), 0);
    chk("f_end_state", 32'(dut.state), 32'(IDLE));

    // Contention: store wins, one IDLE gap, then the fetch.
    @(negedge clk);
    bus.iread   = 1'b1;
    bus.iaddr   = 32'h104;
    bus.dwrite  = 1'b1;
    bus.daddr   = 32'h2000;
    bus.dstore  = 32'hDEAD_BEEF;
    bus.dstrobe = 4'b0011;
    #1;
    chk("c_idle_wen", 32'(bus.ram_wen), 0);
    @(negedge clk);
    bus.ram_ready = 1'b1;
    #1;
    chk("c_state", 32'(dut.state), 32'(DBUSY));
    chk("c_wen", 32'(bus.ram_wen), 1);
    chk("c_ren", 32'(bus.ram_ren), 0);
    chk("c_addr", bus.ram_addr, 32'h2000);
    chk("c_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
    chk("c_strobe", 32'(bus.ram_strobe), 32'h3);
    chk("c_dhit", 32'(bus.dhit), 1);
    chk("c_ihit", 32'(bus.ihit), 0);
    @(negedge clk);
    bus.dwrite = 1'b0;
    bus.ram_ready = 1'b0;
    #1;
    chk("c_gap_state", 32'(dut.state), 32'(IDLE));
    chk("c_gap_ren", 32'(bus.ram_ren), 0);
    chk("c_gap_dhit", 32'(bus.dhit), 0);
    @(negedge clk);
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 32'h13;
    #1;
    chk("c_istate", 32'(dut.state), 32'(IBUSY));
    chk("c_iaddr", bus.ram_addr, 32'h104);
    chk("c_ihit", 32'(bus.ihit), 1);
    chk("c_iload", bus.iload, 32'h13);
    chk("c_cnt", 32'(dut.starve_cnt), 0);
    @(negedge clk);
    bus.iread = 1'b0;
    bus.ram_ready = 1'b0;
    bus.ram_rdata = '0;

    // Read and write together: treated as a write, held until ready.
    @(negedge clk);
    bus.dread   = 1'b1;
    bus.dwrite  = 1'b1;
    bus.daddr   = 32'h3000;
    bus.dstore  = 32'h1234_5678;
    bus.dstrobe = 4'b1100;
    @(negedge clk); #1;
    chk("b_ren", 32'(bus.ram_ren), 0);
    chk("b_wen", 32'(bus.ram_wen), 1);
    chk("b_strobe", 32'(bus.ram_strobe), 32'hC);
    chk("b_wdata", bus.ram_wdata, 32'h1234_5678);
    chk("b_dhit_early", 32'(bus.dhit), 0);
    @(negedge clk);
    bus.ram_ready = 1'b1;
    #1;
    chk("b_state_held", 32'(dut.state), 32'(DBUSY));
    chk("b_dhit", 32'(bus.dhit), 1);
    @(negedge clk);
    bus.dread = 1'b0;
    bus.dwrite = 1'b0;
    bus.ram_ready = 1'b0;
    #1;

    // Starvation: four loads pass the waiting fetch, then the fetch is forced.
    bus.iread = 1'b1;
    bus.iaddr = 32'h200;
    bus.dread = 1'b1;
    bus.daddr = 32'h400;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.ram_ready = 1'b1;
      bus.ram_rdata = 32'hD0 + 32'(i);
      #1;
      chk("s_dstate", 32'(dut.state), 32'(DBUSY));
      chk("s_dhit", 32'(bus.dhit), 1);
      chk("s_ihit", 32'(bus.ihit), 0);
      chk("s_dload", bus.dload, 32'hD0 + 32'(i));
      chk("s_cnt", 32'(dut.starve_cnt), 32'(i + 1));
      @(negedge clk);
      bus.ram_ready = 1'b0;
      #1;
      chk("s_gap", 32'(dut.state), 32'(IDLE));
    end
    @(negedge clk);
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 32'hAAAA_0000;
    #1;
    chk("s_istate", 32'(dut.state), 32'(IBUSY));
    chk("s_forced_ihit", 32'(bus.ihit), 1);
    chk("s_forced_dhit", 32'(bus.dhit), 0);
    chk("s_iload", bus.iload, 32'hAAAA_0000);
    chk("s_cnt_clr", 32'(dut.starve_cnt), 0);
    @(negedge clk);
    bus.iread = 1'b0;
    bus.dread = 1'b0;
    bus.ram_ready = 1'b0;
    bus.ram_rdata = '0;
    #1;
    chk("s_end_state", 32'(dut.state), 32'(IDLE));
    chk("s_end_cnt", 32'(dut.starve_cnt), 0);

    // Fetch abort: iread drops mid-IBUSY, later ready is ignored.
    @(negedge clk);
    bus.iread = 1'b1;
    bus.iaddr = 32'h300;
    @(negedge clk); #1;
    chk("a_state", 32'(dut.state), 32'(IBUSY));
    chk("a_ren", 32'(bus.ram_ren), 1);
    @(negedge clk);
    bus.iread = 1'b0;
    #1;
    chk("a_ihit", 32'(bus.ihit), 0);
    @(negedge clk);
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 32'h55;
    #1;
    chk("a_idle", 32'(dut.state), 32'(IDLE));
    chk("a_late_ihit", 32'(bus.ihit), 0);
    chk("a_late_dhit", 32'(bus.dhit), 0);
    chk("a_late_ren", 32'(bus.ram_ren), 0);
    @(negedge clk);
    bus.ram_ready = 1'b0;
    bus.ram_rdata = '0;
    #1;
    chk("a_idle2", 32'(dut.state), 32'(IDLE));

    // Reset during DBUSY: dropped at once, then serviced after release.
    @(negedge clk);
    bus.dread = 1'b1;
    bus.daddr = 32'h500;
    @(negedge clk); #1;
    chk("r_state", 32'(dut.state), 32'(DBUSY));
    chk("r_ren", 32'(bus.ram_ren), 1);
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 32'h77;
    nrst = 1'b0;
    #1;
    chk("r_rst_state", 32'(dut.state), 32'(IDLE));
    chk("r_rst_dhit", 32'(bus.dhit), 0);
    chk("r_rst_ren", 32'(bus.ram_ren), 0);
    chk("r_rst_dload", bus.dload, 32'h0);
    chk("r_rst_addr", bus.ram_addr, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    bus.ram_ready = 1'b0;
    #1;
    chk("r_rel_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    bus.ram_ready = 1'b1;
    #1;
    chk("r_dstate", 32'(dut.state), 32'(DBUSY));
    chk("r_dhit", 32'(bus.dhit), 1);
    chk("r_dload", bus.dload, 32'h77);
    chk("r_addr", bus.ram_addr, 32'h500);
    @(negedge clk);
    bus.dread = 1'b0;
    bus.ram_ready = 1'b0;
    #1;
    chk("r_end_state", 32'(dut.state), 32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive data grants allowed while an instruction read waits.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port nrst  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port iread  in  1  instruction fetch request, held until ihit.
REQ-005 SHALL have port iaddr  in  32  instruction byte address.
REQ-006 SHALL have port ihit  out  1  instruction access complete, single-cycle pulse.
REQ-007 SHALL have port iload  out  32  instruction read data, valid when ihit=1.
REQ-008 SHALL have port dread  in  1  data load request, held until dhit.
REQ-009 SHALL have port dwrite  in  1  data store request, held until dhit.
REQ-010 SHALL have port daddr  in  32  data byte address.
REQ-011 SHALL have port dstore  in  32  store data.
REQ-012 SHALL have port dstrobe  in  4  store byte enables.
REQ-013 SHALL have port dhit  out  1  data access complete, single-cycle pulse.
REQ-014 SHALL have port dload  out  32  load data, valid when dhit=1.
REQ-015 SHALL have port ram_ren  out  1  RAM read enable.
REQ-016 SHALL have port ram_wen  out  1  RAM write enable.
REQ-017 SHALL have port ram_addr  out  32  RAM byte address.
REQ-018 SHALL have port ram_wdata  out  32  RAM write data.
REQ-019 SHALL have port ram_strobe  out  4  RAM byte enables; 4'b1111 on reads.
REQ-020 SHALL have port ram_rdata  in  32  RAM read data.
REQ-021 SHALL have port ram_ready  in  1  RAM access complete this cycle.

Function
REQ-022 SHALL implement FSM states IDLE, IBUSY, DBUSY.
REQ-023 In IDLE, if (dread|dwrite) and not (iread and starve_cnt==STARVE_MAX), SHALL go to DBUSY next cycle.
REQ-024 Otherwise in IDLE, if iread, SHALL go to IBUSY next cycle; with no request it SHALL stay in IDLE.
REQ-025 In IDLE, all ram_* enables SHALL be 0, and ihit and dhit SHALL be 0.
REQ-026 In IBUSY: ram_ren=1, ram_wen=0, ram_addr=iaddr, ram_strobe=4'b1111.
REQ-027 In DBUSY: ram_ren=dread, ram_wen=dwrite, ram_addr=daddr, ram_wdata=dstore, ram_strobe=dwrite?dstrobe:4'b1111.
REQ-028 dread and dwrite both high SHALL be treated as a write; ram_ren SHALL be 0 in that case.
REQ-029 ihit SHALL equal (state==IBUSY)&ram_ready and dhit SHALL equal (state==DBUSY)&ram_ready, combinationally; iload and dload SHALL pass ram_rdata through.
REQ-030 On ram_ready in IBUSY or DBUSY, SHALL return to IDLE next cycle; minimum request-to-hit latency is 1 cycle, and back-to-back accesses incur one IDLE cycle.
REQ-031 In IBUSY with iread=0 and ram_ready=0 (fetch flushed), SHALL return to IDLE with no ihit.
REQ-032 DBUSY SHALL never be abandoned before ram_ready.
REQ-033 starve_cnt (3 bits minimum) SHALL increment, saturating at STARVE_MAX, on each IDLE->DBUSY transition while iread=1.
REQ-034 starve_cnt SHALL clear on IDLE->IBUSY and whenever iread=0 in IDLE.
REQ-035 ihit and dhit SHALL never be asserted in the same cycle.

Reset
REQ-036 On nrst=0, SHALL asynchronously set state=IDLE and starve_cnt=0.
REQ-037 During reset, all outputs SHALL be 0 (iload/dload are don't-care but SHALL be gated to 0).
REQ-038 Reset asserted mid-access SHALL drop the access without a hit; after release, the block SHALL restart arbitration from IDLE.

Structure
REQ-039 The FSM state enum (arb_state_t) SHALL be placed in common_types_pkg.
REQ-040 The block SHALL be a single module with no sub-modules; the RAM model is external.

Verification
REQ-041 Reset: nrst=0 for 2 cycles then 1, no requests -> all outputs 0, state IDLE.
REQ-042 Single fetch: iread=1, iaddr=0x100, ram_ready after 3 cycles with rdata 0x00500093 -> ram_ren=1 and ram_addr=0x100 throughout; ihit for one cycle with iload=0x00500093.
REQ-043 Contention: iread and dwrite rise together, daddr=0x2000, dstore=0xDEADBEEF, dstrobe=4'b0011 -> data serviced first with ram_wen=1 and strobe 0011; dhit; one IDLE cycle; then the fetch.
REQ-044 Starvation: iread held, dread re-asserted every access, STARVE_MAX=4 -> exactly 4 dhits, then one ihit, then starve_cnt=0.
REQ-045 Fetch abort: iread drops in IBUSY before ram_ready -> IDLE next cycle, no ihit; a later ram_ready pulse has no effect.
REQ-046 Mid-access reset: nrst=0 during DBUSY -> immediate IDLE, no dhit; a fresh request after release is serviced normally.
